// File: rtl/boot_mem_responder.sv
// Memory-side responder for the 8-bit CPU bus.
// Owns a 2^AW x DW single-port RAM with a one-cycle registered read. After reset it holds the
// CPU while a host streams a program image into RAM from address 0, then releases the CPU.
module boot_mem_responder #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  // CPU side
  input  logic          i_csel,
  input  logic          i_read_enable,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_write_data,
  output logic [DW-1:0] o_dataout,
  // Program-load side
  input  logic          i_load_valid,
  input  logic [DW-1:0] i_load_data,
  input  logic          i_load_last,
  output logic          o_load_ready,
  input  logic          i_load_req,
  output logic          o_cpu_hold,
  output logic [AW-1:0] o_load_ptr,
  output logic          o_access_err
);

  typedef enum logic {StLoad, StRun} state_e;

  state_e        r_state;
  logic [AW-1:0] r_load_ptr;
  logic [DW-1:0] r_dataout;
  logic          r_access_err;
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  logic w_in_load;
  logic w_load_fire;
  logic w_cpu_wr;
  logic w_cpu_rd;
  logic w_ptr_at_end;

  assign w_in_load    = (r_state == StLoad);
  assign w_load_fire  = w_in_load && i_load_valid;
  assign w_cpu_wr     = !w_in_load && i_csel && !i_read_enable;
  assign w_cpu_rd     = !w_in_load && i_csel && i_read_enable;
  assign w_ptr_at_end = (r_load_ptr == {AW{1'b1}});

  // RAM write port: loader owns it in LOAD, CPU in RUN. Contents are never reset.
  always_ff @(posedge i_clk) begin
    if (w_load_fire) begin
      r_mem[r_load_ptr] <= i_load_data;
    end else if (w_cpu_wr) begin
      r_mem[i_addr] <= i_write_data;
    end
  end

  // LOAD/RUN control, load pointer, registered read data and sticky access error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StLoad;
      r_load_ptr   <= '0;
      r_dataout    <= '0;
      r_access_err <= 1'b0;
    end else begin
      unique case (r_state)
        StLoad: begin
          // CPU accesses are dropped while loading, but flagged.
          if (i_csel) begin
            r_access_err <= 1'b1;
          end
          if (w_load_fire) begin
            r_load_ptr <= r_load_ptr + AW'(1);
            // Leave on an explicit last byte or once the whole RAM is filled.
            if (i_load_last || w_ptr_at_end) begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          if (w_cpu_rd) begin
            r_dataout <= r_mem[i_addr];
          end
          // A CPU access in the same cycle still completes above.
          if (i_load_req) begin
            r_state    <= StLoad;
            r_load_ptr <= '0;
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

  assign o_load_ready = w_in_load;
  assign o_cpu_hold   = w_in_load;
  assign o_load_ptr   = r_load_ptr;
  assign o_dataout    = r_dataout;
  assign o_access_err = r_access_err;

endmodule

// File: tb/tb_boot_mem_responder.sv
// Self-checking bench for boot_mem_responder: a RAM model supplies expected read data, which is
// queued when a read is driven and compared when dataout updates.
module tb_boot_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       csel;
  logic       read_enable;
  logic [7:0] addr;
  logic [7:0] write_data;
  logic [7:0] dataout;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_req;
  logic       cpu_hold;
  logic [7:0] load_ptr;
  logic       access_err;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr;
  logic [7:0] m_dout;
  logic [7:0] sb_q [$];

  always #5 clk = ~clk;

  boot_mem_responder #(.AW(8), .DW(8)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_csel       (csel),
    .i_read_enable(read_enable),
    .i_addr       (addr),
    .i_write_data (write_data),
    .o_dataout    (dataout),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .i_load_last  (load_last),
    .o_load_ready (load_ready),
    .i_load_req   (load_req),
    .o_cpu_hold   (cpu_hold),
    .o_load_ptr   (load_ptr),
    .o_access_err (access_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check_eq({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    check_eq({tag, "_load_ptr"},   32'(load_ptr),   32'd0);
    check_eq({tag, "_dataout"},    32'(dataout),    32'd0);
    check_eq({tag, "_access_err"}, 32'(access_err), 32'd0);
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    m_mem[m_ptr] = d;
    m_ptr = m_ptr + 8'd1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    csel = 1'b1; read_enable = 1'b0; addr = a; write_data = d;
    @(posedge clk);
    #1;
    csel = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] a);
    logic [7:0] exp;
    csel = 1'b1; read_enable = 1'b1; addr = a;
    sb_q.push_back(m_mem[a]);
    @(posedge clk);
    #1;
    csel = 1'b0;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check_eq(tag, 32'(dataout), 32'(exp));
      m_dout = exp;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; csel = 1'b0; read_enable = 1'b0; addr = '0; write_data = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; load_req = 1'b0;
    m_ptr = '0; m_dout = '0;
    #2;
    check_reset_state("rst");
    #10;
    rst_n = 1'b1;

    // Short image, load_last on third byte.
    load_byte(8'h10, 1'b0);
    load_byte(8'h20, 1'b0);
    check_eq("short_ready_mid", 32'(load_ready), 32'd1);
    load_byte(8'h30, 1'b1);
    check_eq("short_ready_after", 32'(load_ready), 32'd0);
    check_eq("short_hold_after",  32'(cpu_hold),   32'd0);
    check_eq("short_ptr",         32'(load_ptr),   32'd3);
    cpu_read("short_rd2", 8'h02);
    cpu_read("short_rd0", 8'h00);

    // RUN write then read-after-write, then csel=0 hold.
    cpu_write(8'h80, 8'h5C);
    cpu_read("raw_rd80", 8'h80);
    read_enable = 1'b1; addr = 8'h00;
    idle_cycle();
    check_eq("idle_hold", 32'(dataout), 32'(m_dout));
    cpu_write(8'h06, 8'h66);
    check_eq("wr_dout_hold", 32'(dataout), 32'(m_dout));

    // load_req together with a CPU write: write still lands.
    csel = 1'b1; read_enable = 1'b0; addr = 8'h05; write_data = 8'h11; load_req = 1'b1;
    @(posedge clk);
    #1;
    csel = 1'b0; load_req = 1'b0;
    m_mem[8'h05] = 8'h11;
    m_ptr = '0;
    check_eq("req_ready", 32'(load_ready), 32'd1);
    check_eq("req_hold",  32'(cpu_hold),   32'd1);
    check_eq("req_ptr",   32'(load_ptr),   32'd0);
    check_eq("req_err",   32'(access_err), 32'd0);

    // CPU access during LOAD: dropped and flagged.
    csel = 1'b1; read_enable = 1'b0; addr = 8'h06; write_data = 8'hEE;
    idle_cycle();
    read_enable = 1'b1;
    idle_cycle();
    csel = 1'b0;
    check_eq("load_cs_err",  32'(access_err), 32'd1);
    check_eq("load_cs_dout", 32'(dataout),    32'(m_dout));
    check_eq("load_cs_ptr",  32'(load_ptr),   32'd0);
    load_byte(8'h77, 1'b1);
    check_eq("err_sticky_run", 32'(access_err), 32'd1);
    check_eq("one_byte_ptr",   32'(load_ptr),   32'd1);
    cpu_read("req_wr_rd05",  8'h05);
    cpu_read("load_cs_rd06", 8'h06);
    cpu_read("one_byte_rd0", 8'h00);

    // Full 256-byte image with load_last never set.
    load_req = 1'b1;
    idle_cycle();
    load_req = 1'b0;
    m_ptr = '0;
    load_last = 1'b1;
    idle_cycle();
    load_last = 1'b0;
    check_eq("last_no_valid_ready", 32'(load_ready), 32'd1);
    check_eq("last_no_valid_ptr",   32'(load_ptr),   32'd0);
    for (int i = 0; i < 256; i++) begin
      load_byte(8'(i) ^ 8'hA5, 1'b0);
      if (i == 254) begin
        check_eq("full_ready_255", 32'(load_ready), 32'd1);
        check_eq("full_ptr_255",   32'(load_ptr),   32'd255);
      end
    end
    check_eq("full_ready", 32'(load_ready), 32'd0);
    check_eq("full_ptr",   32'(load_ptr),   32'd0);
    cpu_read("full_rd00", 8'h00);
    cpu_read("full_rdff", 8'hFF);
    cpu_read("full_rd80", 8'h80);
    load_valid = 1'b1; load_data = 8'hEE;
    idle_cycle();
    load_valid = 1'b0;
    check_eq("run_valid_ptr", 32'(load_ptr), 32'd0);
    cpu_read("run_valid_rd00", 8'h00);

    // Reset in the middle of a load.
    load_req = 1'b1;
    idle_cycle();
    load_req = 1'b0;
    m_ptr = '0;
    load_byte(8'hB1, 1'b0);
    load_byte(8'hB2, 1'b0);
    check_eq("mid_ptr", 32'(load_ptr), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    m_ptr = '0; m_dout = '0;
    #3;
    rst_n = 1'b1;
    load_byte(8'hC3, 1'b1);
    check_eq("reload_ptr", 32'(load_ptr), 32'd1);
    cpu_read("reload_rd0", 8'h00);
    cpu_read("reload_rd1", 8'h01);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
